// File: rtl/preset_cmd_sequencer.sv
// rtl/preset_cmd_sequencer.sv - drives reset/set pins of a preset register bank and verifies readback
// Optional: define PRESET_STICKY_ERR_EN to make err a sticky failure status held until reset.
module preset_cmd_sequencer #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VAL   = 4'b1101,
  parameter logic [WIDTH-1:0] SET_VAL     = 4'b0110,
  parameter int               HOLD_CYCLES = 2,
  parameter int               TIMEOUT     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_op,
  output logic             req_ready,
  output logic             tgt_reset,
  output logic             tgt_set,
  input  logic [WIDTH-1:0] tgt_q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t          state, state_nx;
  logic            op, op_nx;
  logic [HW-1:0]   hold_cnt, hold_nx;
  logic [TW-1:0]   to_cnt, to_nx;
  logic            done_nx, err_nx, fail;
  logic [WIDTH-1:0] expected;

  assign req_ready = ~busy;

  always_comb begin
    state_nx = state;
    op_nx    = op;
    hold_nx  = hold_cnt;
    to_nx    = to_cnt;
    done_nx  = 1'b0;
    fail     = 1'b0;
    expected = op ? SET_VAL : RESET_VAL;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          op_nx    = req_op;
          hold_nx  = HW'(HOLD_CYCLES - 1);
          state_nx = DRIVE;
        end
      end
      DRIVE: begin
        if (hold_cnt == '0) begin
          state_nx = CHECK;
          to_nx    = '0;
        end else begin
          hold_nx = hold_cnt - 1'b1;
        end
      end
      CHECK: begin
        if (tgt_q == expected) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          fail     = 1'b1;
        end else begin
          to_nx = to_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
`ifdef PRESET_STICKY_ERR_EN
    err_nx = err | fail;
`else
    err_nx = fail;
`endif
  end

  // Drive lines and busy are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op        <= 1'b0;
      hold_cnt  <= '0;
      to_cnt    <= '0;
      tgt_reset <= 1'b0;
      tgt_set   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      op        <= op_nx;
      hold_cnt  <= hold_nx;
      to_cnt    <= to_nx;
      tgt_reset <= (state_nx == DRIVE) && !op_nx;
      tgt_set   <= (state_nx == DRIVE) && op_nx;
      busy      <= (state_nx != IDLE);
      done      <= done_nx;
      err       <= err_nx;
    end
  end

endmodule
